// File: rtl/chip8_sprite_engine.sv
// -----------------------------------------------------------------------------
// chip8_sprite_engine
//
// Multi-cycle DRW (Dxyn) blitter. Accepts one draw request per handshake,
// fetches n sprite rows from the 4 KiB memory and XORs every set sprite bit
// into the 64x32 framebuffer with a read-modify-write. The collision (VF)
// result is reported with a one-cycle done pulse and held afterwards.
//
// Build option:
//   SPRITE_WRAP_EN  defined   -> sprites wrap around both screen edges, all
//                                n rows are always fetched.
//                   undefined -> pixels past the right/bottom edge are
//                                skipped and the draw ends at the first row
//                                below the screen.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_x, req_y            raw Vx/Vy, wrapped to the screen on accept
//   req_n, req_index        row count and sprite base address (I)
//   mem_rd_en/addr/rdata    sprite memory port, 1-cycle read latency
//   fb_rd_en/we/addr        framebuffer port, address = row*64 + col
//   fb_rdata/fb_wdata       pixel read (1-cycle latency) and write data
//   done_valid              one-cycle pulse when the draw is complete
//   collision               VF, valid with done_valid, held until next done
// -----------------------------------------------------------------------------
module chip8_sprite_engine #(
    parameter int FB_W = 64,
    parameter int FB_H = 32
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [3:0]  req_n,
    input  logic [11:0] req_index,
    output logic        mem_rd_en,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        fb_rd_en,
    output logic        fb_we,
    output logic [10:0] fb_addr,
    input  logic [31:0] fb_rdata,
    output logic [31:0] fb_wdata,
    output logic        done_valid,
    output logic        collision
);

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_PIX    = 3'd3;
    localparam logic [2:0] S_PIX_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [3:0]    n_rows;
    logic [11:0]   index;
    logic [3:0]    r;
    logic [2:0]    c;
    logic [7:0]    row_byte;
    logic          coll_flag;
    logic          coll_hold;

    logic [3:0]    r_next;
    logic          bit_set;
    logic          clipped;
    logic          row_end_clip;
    logic          draw;
    logic [10:0]   pix_addr;
    logic [2:0]    col_next_state;

`ifdef SPRITE_WRAP_EN
    // Narrow sums wrap naturally at the screen size.
    logic [XW-1:0] px_w;
    logic [YW-1:0] py_w;

    always_comb begin
        px_w         = x0 + XW'(c);
        py_w         = y0 + YW'(r);
        pix_addr     = {py_w, px_w};
        clipped      = 1'b0;
        row_end_clip = 1'b0;
    end
`else
    // 7-bit sums keep the carry so off-screen pixels can be detected.
    logic [6:0] px;
    logic [6:0] py;
    logic [6:0] py_next;

    always_comb begin
        px           = 7'(x0) + 7'(c);
        py           = 7'(y0) + 7'(r);
        py_next      = 7'(y0) + 7'(r_next);
        pix_addr     = {py[YW-1:0], px[XW-1:0]};
        clipped      = (px >= 7'(FB_W)) || (py >= 7'(FB_H));
        row_end_clip = (py_next >= 7'(FB_H));
    end
`endif

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        r_next  = r + 4'd1;
        // Sprite bit 7 is the leftmost pixel of the row.
        bit_set = row_byte[3'd7 - c];
        draw    = bit_set && !clipped;

        col_next_state = S_PIX;
        if (c == 3'd7) begin
            if (r_next == n_rows || row_end_clip)
                col_next_state = S_DONE;
            else
                col_next_state = S_FETCH;
        end
    end

    // Outputs decode the current state only, so an asynchronous reset
    // silences every strobe in the same instant.
    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_rd_en  = (state == S_FETCH);
        mem_addr   = 12'h000;
        fb_rd_en   = (state == S_PIX) && draw;
        fb_we      = (state == S_PIX_WR);
        fb_addr    = 11'h000;
        fb_wdata   = 32'h0000_0000;
        done_valid = (state == S_DONE);
        collision  = (state == S_DONE) ? coll_flag : coll_hold;

        if (state == S_FETCH)
            mem_addr = index + 12'(r);
        if (fb_rd_en || fb_we)
            fb_addr = pix_addr;
        if (fb_we)
            fb_wdata = fb_rdata ^ 32'hFFFF_FFFF;
    end

    // NOTE: sequential state is assigned with non-blocking assignments so all
    // registers update together from the values seen before the edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= S_IDLE;
            x0        <= '0;
            y0        <= '0;
            n_rows    <= 4'd0;
            index     <= 12'h000;
            r         <= 4'd0;
            c         <= 3'd0;
            row_byte  <= 8'h00;
            coll_flag <= 1'b0;
            coll_hold <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        x0        <= XW'(req_x % 8'(FB_W));
                        y0        <= YW'(req_y % 8'(FB_H));
                        n_rows    <= req_n;
                        index     <= req_index;
                        r         <= 4'd0;
                        c         <= 3'd0;
                        coll_flag <= 1'b0;
                        state     <= (req_n == 4'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    row_byte <= mem_rdata;
                    c        <= 3'd0;
                    state    <= S_PIX;
                end
                S_PIX: begin
                    if (draw) begin
                        state <= S_PIX_WR;
                    end else begin
                        c     <= c + 3'd1;
                        if (c == 3'd7)
                            r <= r_next;
                        state <= col_next_state;
                    end
                end
                S_PIX_WR: begin
                    if (fb_rdata == 32'hFFFF_FFFF)
                        coll_flag <= 1'b1;
                    c     <= c + 3'd1;
                    if (c == 3'd7)
                        r <= r_next;
                    state <= col_next_state;
                end
                S_DONE: begin
                    coll_hold <= coll_flag;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
